alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Single-entry pipeline register that sits in front of the ALU and drives its op-code and operand inputs.
- Decodes a fetched RV32I instruction, selects operands from register data, PC or immediate, and registers the result behind a valid/ready handshake toward execute.
- Supports stall via backpressure and flush on redirect.
- Uses `XLEN, `ALUOPS and the ALU op-code macros (`ADD, `SUB, `SLL, `SLT, `SLTU, `XOR, `SRL, `SRA, `OR, `AND, `EQ, `NEQ, `GE, `GEU) from header.vh.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into o_pc on reset.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  stage can accept; combinational = !o_valid | i_ready.
- i_instr  input  32  instruction word.
- i_pc  input  `XLEN  instruction address.
- ow_rs1_addr  output  5  combinational i_instr[19:15] to register file.
- ow_rs2_addr  output  5  combinational i_instr[24:20] to register file.
- i_rs1_data  input  `XLEN  register file read data, same cycle.
- i_rs2_data  input  `XLEN  register file read data, same cycle.
- i_flush  input  1  kill held and incoming instruction.
- o_valid  output  1  registered; ALU inputs valid.
- i_ready  input  1  execute accepts.
- o_alu_op  output  `ALUOPS  registered ALU op.
- o_data_1  output  `XLEN  registered operand 1.
- o_data_2  output  `XLEN  registered operand 2.
- o_pc  output  `XLEN  registered PC.
- o_rd  output  5  destination register.
- o_we  output  1  register write enable.
- o_branch  output  1  instruction is conditional branch.
- o_illegal  output  1  unsupported or malformed encoding.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_valid=0, o_alu_op=`ADD, o_data_1=o_data_2=0, o_pc=RESET_PC.
  - o_rd=0, o_we=o_branch=o_illegal=0.
- Capture: at posedge, when i_valid & o_ready & !i_flush, all outputs load the decoded instruction and o_valid=1. Latency is one cycle.
- Hold: o_valid & !i_ready -> every output holds its value and o_ready=0.
- Drain: o_valid & i_ready & !(i_valid) -> o_valid=0, other outputs hold.
- Flush: i_flush=1 -> o_valid=0 next edge. Flush has priority over capture and hold; an incoming instruction in that cycle is dropped.
- Decode by opcode i_instr[6:0]; immediates are sign-extended to `XLEN:
  - OP 0110011: funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 selects SUB (f3=000) or SRA (f3=101). Any other funct7≠0 is illegal. data_1=rs1, data_2=rs2, we=1.
  - OP-IMM 0010011: same map with I-immediate as data_2.
    - Shifts use shamt=instr[24:20].
    - SLLI requires funct7=0.
    - SRLI/SRAI require funct7=0 or 0100000.
  - LUI 0110111: ADD, data_1=0, data_2={instr[31:12],12'b0}.
  - AUIPC 0010111: ADD, data_1=i_pc, data_2=U-imm.
  - BRANCH 1100011: f3 000/001/100/101/110/111 map to EQ/NEQ/SLT/GE/SLTU/GEU. data_1=rs1, data_2=rs2, we=0, o_branch=1, o_rd=0. f3 010/011 are illegal.
  - Any other opcode is illegal.
- Illegal instruction: o_illegal=1, o_alu_op=`ADD, o_we=0, o_branch=0, operands 0; o_valid still asserts.
- o_rd=instr[11:7]. o_we forced 0 when rd=0.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Enabled, the block adds inputs i_wb_we (1), i_wb_rd (5) and i_wb_data (`XLEN).
  - At capture, if i_wb_we & i_wb_rd≠0 & i_wb_rd==rs1 addr, operand 1 uses i_wb_data instead of i_rs1_data; the same rule applies to rs2.
  - The bypass applies only where the register value is the selected operand.
- Disabled: the ports do not exist and the operands come from the register file only.

Test Plan:
- Reset mid-stream: o_valid=1, then i_rst_n=0 -> all outputs reach reset values immediately, with no clock edge needed.
- ADDI x5,x1,-3 (32'hFFD08293), i_rs1_data=10 -> next cycle: o_valid=1, op=`ADD, data_1=10, data_2=32'hFFFFFFFD, o_rd=5, o_we=1.
- SRAI x3,x3,4 (32'h4041D193) -> op=`SRA, data_2=4.
- Same with funct7=0100001 -> o_illegal=1, o_we=0.
- BGEU x1,x2 (f3=111) with i_ready=0 for 3 cycles -> outputs stable (op=`GEU, o_branch=1, o_we=0), o_ready=0. Release i_ready -> the next instruction is accepted on that edge.
- AUIPC x7,0x12345 at i_pc=32'h100 -> op=`ADD, data_1=32'h100, data_2=32'h12345000.
- i_flush with i_valid=1 and o_valid=1 -> o_valid=0 next cycle. Then LUI x0,1 -> o_we=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode and operand-select register in front of the ALU.
// Optional build macro ISSUE_WB_BYPASS_EN forwards same-cycle writeback data into register operands.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS
`define ALUOPS 4
`endif
`ifndef ADD
`define ADD  4'd0
`define SUB  4'd1
`define SLL  4'd2
`define SLT  4'd3
`define SLTU 4'd4
`define XOR  4'd5
`define SRL  4'd6
`define SRA  4'd7
`define OR   4'd8
`define AND  4'd9
`define EQ   4'd10
`define NEQ  4'd11
`define GE   4'd12
`define GEU  4'd13
`endif

module alu_issue_stage #(
    parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic [`XLEN-1:0]   i_pc,
    output logic [4:0]         ow_rs1_addr,
    output logic [4:0]         ow_rs2_addr,
    input  logic [`XLEN-1:0]   i_rs1_data,
    input  logic [`XLEN-1:0]   i_rs2_data,
`ifdef ISSUE_WB_BYPASS_EN
    input  logic               i_wb_we,
    input  logic [4:0]         i_wb_rd,
    input  logic [`XLEN-1:0]   i_wb_data,
`endif
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [`ALUOPS-1:0] o_alu_op,
    output logic [`XLEN-1:0]   o_data_1,
    output logic [`XLEN-1:0]   o_data_2,
    output logic [`XLEN-1:0]   o_pc,
    output logic [4:0]         o_rd,
    output logic               o_we,
    output logic               o_branch,
    output logic               o_illegal
);
    logic [6:0]         opc, f7;
    logic [2:0]         f3;
    logic [`XLEN-1:0]   imm_i, imm_u, shamt, rs1_v, rs2_v;
    logic [`ALUOPS-1:0] base_op, br_op, op_d, op_q;
    logic [`XLEN-1:0]   d1_d, d2_d, d1_q, d2_q, pc_q;
    logic [4:0]         rd_d, rd_q;
    logic               we_d, br_d, ill_d, we_q, br_q, ill_q, valid_q, cap;

    assign opc         = i_instr[6:0];
    assign f3          = i_instr[14:12];
    assign f7          = i_instr[31:25];
    assign ow_rs1_addr = i_instr[19:15];
    assign ow_rs2_addr = i_instr[24:20];
    assign imm_i       = `XLEN'($signed(i_instr[31:20]));
    assign imm_u       = `XLEN'($signed({i_instr[31:12], 12'b0}));
    assign shamt       = `XLEN'(i_instr[24:20]);
`ifdef ISSUE_WB_BYPASS_EN
    assign rs1_v = (i_wb_we && i_wb_rd != 5'd0 && i_wb_rd == ow_rs1_addr) ? i_wb_data : i_rs1_data;
    assign rs2_v = (i_wb_we && i_wb_rd != 5'd0 && i_wb_rd == ow_rs2_addr) ? i_wb_data : i_rs2_data;
`else
    assign rs1_v = i_rs1_data;
    assign rs2_v = i_rs2_data;
`endif
    assign o_ready = !valid_q || i_ready;
    assign cap     = i_valid && o_ready && !i_flush;

    // funct3 to ALU op for register/immediate arithmetic and for branch compares
    always_comb begin
        base_op = `ADD;
        br_op   = `EQ;
        case (f3)
            3'b000: begin base_op = `ADD;  br_op = `EQ;   end
            3'b001: begin base_op = `SLL;  br_op = `NEQ;  end
            3'b010: begin base_op = `SLT;  br_op = `EQ;   end
            3'b011: begin base_op = `SLTU; br_op = `EQ;   end
            3'b100: begin base_op = `XOR;  br_op = `SLT;  end
            3'b101: begin base_op = `SRL;  br_op = `GE;   end
            3'b110: begin base_op = `OR;   br_op = `SLTU; end
            default: begin base_op = `AND; br_op = `GEU;  end
        endcase
    end

    // Opcode decode and operand selection; illegal encodings collapse to a harmless ADD 0,0
    always_comb begin
        op_d  = base_op;
        d1_d  = rs1_v;
        d2_d  = rs2_v;
        rd_d  = i_instr[11:7];
        we_d  = 1'b1;
        br_d  = 1'b0;
        ill_d = 1'b0;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'b0100000 && f3 == 3'b000) op_d = `SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101) op_d = `SRA;
                else ill_d = f7 != 7'b0;
            end
            7'b0010011: begin
                d2_d = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
                op_d = (f3 == 3'b101 && f7 == 7'b0100000) ? `SRA : base_op;
                ill_d = (f3 == 3'b001 && f7 != 7'b0) ||
                        (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
            end
            7'b0110111: begin op_d = `ADD; d1_d = '0;   d2_d = imm_u; end
            7'b0010111: begin op_d = `ADD; d1_d = i_pc; d2_d = imm_u; end
            7'b1100011: begin
                op_d  = br_op;
                we_d  = 1'b0;
                br_d  = 1'b1;
                rd_d  = 5'd0;
                ill_d = f3[2:1] == 2'b01;
            end
            default: ill_d = 1'b1;
        endcase
        if (ill_d) begin
            op_d = `ADD;
            d1_d = '0;
            d2_d = '0;
            rd_d = i_instr[11:7];
            we_d = 1'b0;
            br_d = 1'b0;
        end
        if (rd_d == 5'd0) we_d = 1'b0;
    end

    // Handshake register: flush kills, stall holds, drain clears valid, capture loads decode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            op_q    <= `ADD;
            d1_q    <= '0;
            d2_q    <= '0;
            pc_q    <= RESET_PC;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= i_flush ? 1'b0 : (o_ready ? i_valid : valid_q);
            if (cap) begin
                op_q  <= op_d;
                d1_q  <= d1_d;
                d2_q  <= d2_d;
                pc_q  <= i_pc;
                rd_q  <= rd_d;
                we_q  <= we_d;
                br_q  <= br_d;
                ill_q <= ill_d;
            end
        end
    end

    assign o_valid   = valid_q;
    assign o_alu_op  = op_q;
    assign o_data_1  = d1_q;
    assign o_data_2  = d2_q;
    assign o_pc      = pc_q;
    assign o_rd      = rd_q;
    assign o_we      = we_q;
    assign o_branch  = br_q;
    assign o_illegal = ill_q;
endmodule
